// File: rtl/alu_issue_ctrl_if.sv
// Handshake and datapath bundle between the ALU issue controller and its
// surroundings: instruction intake, register bank ports, ALU ports and the
// response channel.
interface alu_issue_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
);
    logic              instr_valid;
    logic              instr_ready;
    logic [31:0]       instr;
    logic [ADDR_W-1:0] rb_ra1;
    logic [ADDR_W-1:0] rb_ra2;
    logic [DATA_W-1:0] rb_rd1;
    logic [DATA_W-1:0] rb_rd2;
    logic              rb_we;
    logic [ADDR_W-1:0] rb_wa;
    logic [DATA_W-1:0] rb_wd;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [2:0]        alu_op;
    logic [DATA_W-1:0] alu_result;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_err;
    logic [CNT_W-1:0]  retired_cnt;

    // Controller side: issues reads/ALU ops/writes and answers with a response.
    modport master (
        input  instr_valid, instr, rb_rd1, rb_rd2, alu_result, rsp_ready,
        output instr_ready, rb_ra1, rb_ra2, rb_we, rb_wa, rb_wd,
               alu_a, alu_b, alu_op, rsp_valid, rsp_result, rsp_err, retired_cnt
    );

    // Environment side: fetch/decode, register bank, ALU and response consumer.
    modport slave (
        output instr_valid, instr, rb_rd1, rb_rd2, alu_result, rsp_ready,
        input  instr_ready, rb_ra1, rb_ra2, rb_we, rb_wa, rb_wd,
               alu_a, alu_b, alu_op, rsp_valid, rsp_result, rsp_err, retired_cnt
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: takes one R-type instruction at a time, reads both
// operands from the register bank, presents them to the combinational ALU,
// writes the result back (never to r0) and returns result/status on a
// response handshake. Illegal encodings skip straight to an error response.
module alu_issue_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic           clk,
    input  logic           rst,
    alu_issue_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        EXEC = 3'd2,
        WB   = 3'd3,
        RESP = 3'd4
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic              legal_s;
    logic [2:0]        func_r;
    logic [ADDR_W-1:0] rs_r;
    logic [ADDR_W-1:0] rt_r;
    logic [ADDR_W-1:0] rd_r;
    logic [DATA_W-1:0] alu_a_r;
    logic [DATA_W-1:0] alu_b_r;
    logic [2:0]        alu_op_r;
    logic              rb_we_r;
    logic [DATA_W-1:0] rsp_result_r;
    logic              rsp_err_r;
    logic [CNT_W-1:0]  cnt_r;

    // Upper bits must be clear and func must name one of the five ALU ops.
    function automatic logic is_legal(input logic [31:0] ins);
        logic func_ok;
        case (ins[17:15])
            3'b000, 3'b001, 3'b010, 3'b011, 3'b101: func_ok = 1'b1;
            default:                                func_ok = 1'b0;
        endcase
        return (ins[31:18] == 14'd0) && func_ok;
    endfunction

    assign legal_s = is_legal(bus.instr);

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic for the IDLE->READ->EXEC->WB->RESP sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.instr_valid) begin
                    state_s = legal_s ? READ : RESP;
                end else begin
                    state_s = IDLE;
                end
            end
            READ: state_s = EXEC;
            EXEC: state_s = WB;
            WB:   state_s = RESP;
            RESP: begin
                if (bus.rsp_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Instruction latch, operand/result capture, write strobe and retire counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            func_r       <= 3'd0;
            rs_r         <= {ADDR_W{1'b0}};
            rt_r         <= {ADDR_W{1'b0}};
            rd_r         <= {ADDR_W{1'b0}};
            alu_a_r      <= {DATA_W{1'b0}};
            alu_b_r      <= {DATA_W{1'b0}};
            alu_op_r     <= 3'd0;
            rb_we_r      <= 1'b0;
            rsp_result_r <= {DATA_W{1'b0}};
            rsp_err_r    <= 1'b0;
            cnt_r        <= {CNT_W{1'b0}};
        end else begin
            // The strobe is set on entry to WB so it is high for exactly that cycle.
            rb_we_r <= (state_r == EXEC) && (rd_r != {ADDR_W{1'b0}});
            if ((state_r == IDLE) && bus.instr_valid) begin
                func_r <= bus.instr[17:15];
                rs_r   <= bus.instr[14:10];
                rt_r   <= bus.instr[9:5];
                rd_r   <= bus.instr[4:0];
                if (!legal_s) begin
                    rsp_result_r <= {DATA_W{1'b0}};
                    rsp_err_r    <= 1'b1;
                end
            end
            // Bank read data arrives one cycle after the address, i.e. during EXEC.
            if (state_r == EXEC) begin
                alu_a_r  <= bus.rb_rd1;
                alu_b_r  <= bus.rb_rd2;
                alu_op_r <= func_r;
            end
            if (state_r == WB) begin
                rsp_result_r <= bus.alu_result;
                rsp_err_r    <= 1'b0;
            end
            if ((state_r == RESP) && bus.rsp_ready && !rsp_err_r) begin
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign bus.instr_ready = (state_r == IDLE);
    assign bus.rsp_valid   = (state_r == RESP);
    assign bus.rb_ra1      = rs_r;
    assign bus.rb_ra2      = rt_r;
    assign bus.rb_we       = rb_we_r;
    assign bus.rb_wa       = rd_r;
    // The ALU is combinational on registered operands, so write data is taken
    // straight from it during WB and held at zero otherwise.
    assign bus.rb_wd       = (state_r == WB) ? bus.alu_result : {DATA_W{1'b0}};
    assign bus.alu_a       = alu_a_r;
    assign bus.alu_b       = alu_b_r;
    assign bus.alu_op      = alu_op_r;
    assign bus.rsp_result  = rsp_result_r;
    assign bus.rsp_err     = rsp_err_r;
    assign bus.retired_cnt = cnt_r;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a registered-read register bank model
// and a combinational ALU model. The counter is built 4 bits wide so its
// wrap from all-ones to zero is reachable in a short run.
module tb_alu_issue_ctrl;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   we_total = 0;
    logic [CNT_W-1:0] exp_cnt = 4'd0;

    logic [31:0] bank [32];
    logic        ld_en = 1'b0;
    logic [4:0]  ld_a  = 5'd0;
    logic [31:0] ld_d  = 32'd0;

    alu_issue_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    alu_issue_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Register bank: registered read, write when enabled and not r0, bench preload port.
    always @(posedge clk) begin
        bus.rb_rd1 <= bank[bus.rb_ra1];
        bus.rb_rd2 <= bank[bus.rb_ra2];
        if (ld_en) begin
            bank[ld_a] <= ld_d;
        end else if (bus.rb_we && (bus.rb_wa != 5'd0)) begin
            bank[bus.rb_wa] <= bus.rb_wd;
        end
    end

    // Combinational ALU model.
    always_comb begin
        bus.alu_result = 32'd0;
        case (bus.alu_op)
            3'b000:  bus.alu_result = bus.alu_a + bus.alu_b;
            3'b001:  bus.alu_result = bus.alu_a - bus.alu_b;
            3'b010:  bus.alu_result = bus.alu_a & bus.alu_b;
            3'b011:  bus.alu_result = bus.alu_a | bus.alu_b;
            3'b101:  bus.alu_result = (bus.alu_a < bus.alu_b) ? 32'd1 : 32'd0;
            default: bus.alu_result = 32'd0;
        endcase
    end

    // Count every write strobe seen on a clock edge.
    always @(posedge clk) begin
        if (bus.rb_we) we_total <= we_total + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [2:0] f, input logic [4:0] s,
                                       input logic [4:0] t, input logic [4:0] d);
        return {14'd0, f, s, t, d};
    endfunction

    task automatic preload(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_a = a; ld_d = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic wait_ready();
        int w = 0;
        @(negedge clk);
        while (!bus.instr_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check_eq("instr_ready", {31'd0, bus.instr_ready}, 32'd1);
    endtask

    // Issue one instruction, track write strobe and response timing, then retire it.
    task automatic run_op(input string tag, input logic [31:0] ins, input logic [31:0] exp_res,
                          input bit exp_err, input bit exp_we, input int stall);
        int we_cyc = 0;
        int we_cnt = 0;
        int rsp_cyc = 0;
        logic [4:0]  wa_seen = 5'd0;
        logic [31:0] wd_seen = 32'd0;
        logic [4:0]  ra1_seen = 5'd0;
        logic [4:0]  ra2_seen = 5'd0;
        wait_ready();
        bus.instr_valid = 1'b1;
        bus.instr       = ins;
        bus.rsp_ready   = (stall == 0);
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        bus.instr       = 32'hFFFF_FFFF;
        for (int k = 1; k <= 8 && rsp_cyc == 0; k++) begin
            @(negedge clk);
            if (k == 2) begin
                ra1_seen = bus.rb_ra1;
                ra2_seen = bus.rb_ra2;
            end
            if (bus.rb_we) begin
                we_cnt++;
                we_cyc  = k;
                wa_seen = bus.rb_wa;
                wd_seen = bus.rb_wd;
            end
            if (bus.rsp_valid) rsp_cyc = k;
        end
        check_eq({tag, "_rsp_cycle"}, rsp_cyc, exp_err ? 32'd1 : 32'd4);
        check_eq({tag, "_result"}, bus.rsp_result, exp_res);
        check_eq({tag, "_err"}, {31'd0, bus.rsp_err}, {31'd0, exp_err});
        check_eq({tag, "_we_count"}, we_cnt, exp_we ? 32'd1 : 32'd0);
        if (exp_we) begin
            check_eq({tag, "_we_cycle"}, we_cyc, 32'd3);
            check_eq({tag, "_wa"}, {27'd0, wa_seen}, {27'd0, ins[4:0]});
            check_eq({tag, "_wd"}, wd_seen, exp_res);
        end
        if (!exp_err) begin
            check_eq({tag, "_ra1"}, {27'd0, ra1_seen}, {27'd0, ins[14:10]});
            check_eq({tag, "_ra2"}, {27'd0, ra2_seen}, {27'd0, ins[9:5]});
        end
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check_eq({tag, "_stall_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
            check_eq({tag, "_stall_result"}, bus.rsp_result, exp_res);
            check_eq({tag, "_stall_ready"}, {31'd0, bus.instr_ready}, 32'd0);
            check_eq({tag, "_stall_cnt"}, {28'd0, bus.retired_cnt}, {28'd0, exp_cnt});
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!exp_err) exp_cnt = exp_cnt + 4'd1;
        check_eq({tag, "_post_valid"}, {31'd0, bus.rsp_valid}, 32'd0);
        check_eq({tag, "_post_ready"}, {31'd0, bus.instr_ready}, 32'd1);
        check_eq({tag, "_cnt"}, {28'd0, bus.retired_cnt}, {28'd0, exp_cnt});
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_instr_ready"}, {31'd0, bus.instr_ready}, 32'd1);
        check_eq({tag, "_rb_we"}, {31'd0, bus.rb_we}, 32'd0);
        check_eq({tag, "_rsp_valid"}, {31'd0, bus.rsp_valid}, 32'd0);
        check_eq({tag, "_rsp_err"}, {31'd0, bus.rsp_err}, 32'd0);
        check_eq({tag, "_rsp_result"}, bus.rsp_result, 32'd0);
        check_eq({tag, "_ra1"}, {27'd0, bus.rb_ra1}, 32'd0);
        check_eq({tag, "_ra2"}, {27'd0, bus.rb_ra2}, 32'd0);
        check_eq({tag, "_wa"}, {27'd0, bus.rb_wa}, 32'd0);
        check_eq({tag, "_wd"}, bus.rb_wd, 32'd0);
        check_eq({tag, "_alu_a"}, bus.alu_a, 32'd0);
        check_eq({tag, "_alu_b"}, bus.alu_b, 32'd0);
        check_eq({tag, "_alu_op"}, {29'd0, bus.alu_op}, 32'd0);
        check_eq({tag, "_cnt"}, {28'd0, bus.retired_cnt}, 32'd0);
    endtask

    initial begin
        int we_before;
        bus.instr_valid = 1'b0;
        bus.instr       = 32'd0;
        bus.rsp_ready   = 1'b1;
        for (int i = 0; i < 32; i++) preload(i[4:0], 32'd0);
        preload(5'd1, 32'd10);
        preload(5'd2, 32'd5);
        preload(5'd4, 32'd15);
        preload(5'd7, 32'hA);
        preload(5'd8, 32'hC);
        preload(5'd9, 32'd5);
        preload(5'd10, 32'd10);
        @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;

        run_op("add", mk(3'b000, 5'd1, 5'd2, 5'd3), 32'd15, 1'b0, 1'b1, 0);
        run_op("sub", mk(3'b001, 5'd4, 5'd2, 5'd6), 32'd10, 1'b0, 1'b1, 0);
        run_op("and", mk(3'b010, 5'd7, 5'd8, 5'd11), 32'h8, 1'b0, 1'b1, 0);
        run_op("or",  mk(3'b011, 5'd7, 5'd8, 5'd12), 32'hE, 1'b0, 1'b1, 0);
        run_op("slt_lt", mk(3'b101, 5'd9, 5'd10, 5'd13), 32'd1, 1'b0, 1'b1, 0);
        run_op("slt_ge", mk(3'b101, 5'd10, 5'd9, 5'd14), 32'd0, 1'b0, 1'b1, 0);
        run_op("bad_func", mk(3'b100, 5'd1, 5'd2, 5'd3), 32'd0, 1'b1, 1'b0, 0);
        run_op("bad_hi", mk(3'b000, 5'd1, 5'd2, 5'd3) | 32'h0010_0000, 32'd0, 1'b1, 1'b0, 0);
        run_op("add_r0", mk(3'b000, 5'd1, 5'd2, 5'd0), 32'd15, 1'b0, 1'b0, 0);
        // Uses r3 and r6 written back by the first two operations.
        run_op("add_wb", mk(3'b000, 5'd3, 5'd6, 5'd15), 32'd25, 1'b0, 1'b1, 0);
        run_op("stall", mk(3'b011, 5'd7, 5'd8, 5'd16), 32'hE, 1'b0, 1'b1, 5);

        // Reset while the operation sits in EXEC.
        wait_ready();
        bus.instr_valid = 1'b1;
        bus.instr       = mk(3'b000, 5'd1, 5'd2, 5'd18);
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        we_before = we_total;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 4'd0;
        check_reset_state("rst_exec");
        for (int i = 0; i < 4; i++) @(negedge clk);
        check_eq("rst_exec_no_we", we_total, we_before);
        check_eq("rst_exec_idle_valid", {31'd0, bus.rsp_valid}, 32'd0);

        // Fill the counter to all-ones, then one more retirement wraps it.
        for (int i = 0; i < 15; i++) run_op("fill", mk(3'b000, 5'd1, 5'd2, 5'd17), 32'd15, 1'b0, 1'b1, 0);
        check_eq("cnt_full", {28'd0, bus.retired_cnt}, 32'd15);
        run_op("wrap", mk(3'b001, 5'd1, 5'd2, 5'd19), 32'd5, 1'b0, 1'b1, 0);
        check_eq("cnt_wrap", {28'd0, bus.retired_cnt}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
